// File: rtl/surf_cmd_scheduler.sv
// Trigger-to-command scheduler: allocates SURF digitizer buffers, queues {event ID, buffer}
// and issues them over the sender start/busy/done handshake. Optional watchdog: SCHED_TIMEOUT_EN.
module surf_cmd_scheduler #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        trig_i,
   input  logic [31:0] trig_event_id_i,
   input  logic [3:0]  release_i,
   input  logic        busy_i,
   input  logic        done_i,
   output logic        start_o,
   output logic [31:0] event_id_o,
   output logic [1:0]  buffer_o,
   output logic        trig_ack_o,
   output logic        trig_drop_o,
   output logic [3:0]  buffers_used_o,
   output logic [4:0]  fifo_count_o,
   output logic [15:0] drop_count_o,
   output logic        idle_o,
   output logic        timeout_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("surf_cmd_scheduler: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
   end

   state_t      r_state;
   logic [3:0]  r_used;
   logic [1:0]  r_ptr;
   logic [31:0] r_mem_id  [FIFO_DEPTH];
   logic [1:0]  r_mem_buf [FIFO_DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [4:0]  r_count;
   logic        r_start;
   logic [31:0] r_event_id;
   logic [1:0]  r_buffer;
   logic        r_ack;
   logic        r_drop;
   logic [15:0] r_drop_cnt;
   logic        r_idle;

   logic [1:0]  w_sel;
   logic [1:0]  w_rr_idx;
   logic        w_any_free;
   logic        w_accept;
   logic        w_go;
   logic        w_timeout;
   logic        w_pop;
   logic [4:0]  w_count_nxt;
   logic        w_idle_nxt;

   // Round-robin search for the first free buffer starting at r_ptr; lowest offset wins.
   always_comb begin
      w_sel    = r_ptr;
      w_rr_idx = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         w_rr_idx = r_ptr + 2'(k);
         w_sel    = r_used[w_rr_idx] ? w_sel : w_rr_idx;
      end
   end

   assign w_any_free  = ~&r_used;
   assign w_accept    = trig_i && w_any_free && (r_count < 5'(FIFO_DEPTH));
   assign w_go        = (r_state == ST_IDLE) && (r_count != 5'd0) && !busy_i;
   assign w_pop       = ((r_state == ST_WAIT) && done_i) || w_timeout;
   assign w_count_nxt = r_count + {4'd0, w_accept} - {4'd0, w_pop};
   assign w_idle_nxt  = (((r_state == ST_IDLE) && !w_go) || w_pop) && (w_count_nxt == 5'd0);

   // Allocation, occupancy, queue pointers and trigger accounting.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_used     <= 4'd0;
         r_ptr      <= 2'd0;
         r_wr       <= {AW{1'b0}};
         r_rd       <= {AW{1'b0}};
         r_count    <= 5'd0;
         r_ack      <= 1'b0;
         r_drop     <= 1'b0;
         r_drop_cnt <= 16'd0;
      end else begin
         r_ack   <= w_accept;
         r_drop  <= trig_i && !w_accept;
         r_count <= w_count_nxt;
         // Allocation only ever targets buffers that were free before this cycle.
         r_used  <= (r_used & ~release_i) | (w_accept ? (4'b0001 << w_sel) : 4'd0);
         if (w_accept) begin
            r_ptr <= w_sel + 2'd1;
            r_wr  <= r_wr + AW'(1);
         end
         if (w_pop) begin
            r_rd <= r_rd + AW'(1);
         end
         if (trig_i && !w_accept && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end
   end

   // Queue storage; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_mem_id[r_wr]  <= trig_event_id_i;
         r_mem_buf[r_wr] <= w_sel;
      end
   end

   // Command issue FSM with registered sender outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_start    <= 1'b0;
         r_event_id <= 32'd0;
         r_buffer   <= 2'd0;
         r_idle     <= 1'b1;
      end else begin
         r_idle <= w_idle_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_go) begin
                  r_state    <= ST_ISSUE;
                  r_start    <= 1'b1;
                  r_event_id <= r_mem_id[r_rd];
                  r_buffer   <= r_mem_buf[r_rd];
               end
            end
            ST_ISSUE: begin
               r_start <= 1'b0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_pop) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_start <= 1'b0;
            end
         endcase
      end
   end

`ifdef SCHED_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDW-1:0] r_wd_cnt;
   logic           r_timeout;

   // Done watchdog: counter sits at zero outside WAIT_DONE, so it restarts on every entry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wd_cnt  <= {WDW{1'b0}};
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeout;
         if (r_state != ST_WAIT) begin
            r_wd_cnt <= {WDW{1'b0}};
         end else begin
            r_wd_cnt <= r_wd_cnt + WDW'(1);
         end
      end
   end

   assign w_timeout = (r_state == ST_WAIT) && !done_i && (r_wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
   assign timeout_o = r_timeout;
`else
   assign w_timeout = 1'b0;
   assign timeout_o = 1'b0;
`endif

   assign start_o        = r_start;
   assign event_id_o     = r_event_id;
   assign buffer_o       = r_buffer;
   assign trig_ack_o     = r_ack;
   assign trig_drop_o    = r_drop;
   assign buffers_used_o = r_used;
   assign fifo_count_o   = r_count;
   assign drop_count_o   = r_drop_cnt;
   assign idle_o         = r_idle;

endmodule

// File: tb/tb_surf_cmd_scheduler.sv
// Directed self-checking bench for surf_cmd_scheduler.
module tb_surf_cmd_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trig = 1'b0;
   logic [31:0] trig_id = 32'd0;
   logic [3:0]  rel = 4'd0;
   logic        busy = 1'b0;
   logic        done = 1'b0;

   logic        start_o, trig_ack_o, trig_drop_o, idle_o, timeout_o;
   logic [31:0] event_id_o;
   logic [1:0]  buffer_o;
   logic [3:0]  buffers_used_o;
   logic [4:0]  fifo_count_o;
   logic [15:0] drop_count_o;
   logic [63:0] all_o;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   surf_cmd_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
      .clk_i(clk), .rst_i(rst), .trig_i(trig), .trig_event_id_i(trig_id),
      .release_i(rel), .busy_i(busy), .done_i(done),
      .start_o(start_o), .event_id_o(event_id_o), .buffer_o(buffer_o),
      .trig_ack_o(trig_ack_o), .trig_drop_o(trig_drop_o),
      .buffers_used_o(buffers_used_o), .fifo_count_o(fifo_count_o),
      .drop_count_o(drop_count_o), .idle_o(idle_o), .timeout_o(timeout_o)
   );

   // Reset image is 0 everywhere except idle_o (LSB) = 1.
   assign all_o = {start_o, trig_ack_o, trig_drop_o, timeout_o, event_id_o, buffer_o,
                   buffers_used_o, fifo_count_o, drop_count_o, idle_o};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; trig = 1'b0; rel = 4'd0; busy = 1'b0; done = 1'b0; trig_id = 32'd0;
      tick; tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      chk_cnt++; if (all_o !== 64'd1) $display("FAIL reset_values: got %h want %h", all_o, 64'd1); else pass_cnt++;
      rst = 1'b0;
      tick;
      chk_cnt++; if (all_o !== 64'd1) $display("FAIL reset_quiet: got %h want %h", all_o, 64'd1); else pass_cnt++;
   endtask

   task automatic test_basic;
      do_reset;
      trig = 1'b1; trig_id = 32'h12345678;
      tick;
      trig = 1'b0;
      chk_cnt++; if (trig_ack_o !== 1'b1) $display("FAIL basic_ack: got %b want 1", trig_ack_o); else pass_cnt++;
      chk_cnt++; if (fifo_count_o !== 5'd1) $display("FAIL basic_count: got %0d want 1", fifo_count_o); else pass_cnt++;
      chk_cnt++; if (start_o !== 1'b0) $display("FAIL basic_early_start: got %b want 0", start_o); else pass_cnt++;
      tick;
      chk_cnt++; if (start_o !== 1'b1) $display("FAIL basic_start: got %b want 1", start_o); else pass_cnt++;
      chk_cnt++; if (event_id_o !== 32'h12345678) $display("FAIL basic_event_id: got %h want 12345678", event_id_o); else pass_cnt++;
      chk_cnt++; if (buffer_o !== 2'd0) $display("FAIL basic_buffer: got %0d want 0", buffer_o); else pass_cnt++;
      tick;
      chk_cnt++; if (start_o !== 1'b0) $display("FAIL basic_start_pulse: got %b want 0", start_o); else pass_cnt++;
      done = 1'b1;
      tick;
      done = 1'b0;
      chk_cnt++; if (idle_o !== 1'b1) $display("FAIL basic_idle: got %b want 1", idle_o); else pass_cnt++;
      chk_cnt++; if (buffers_used_o !== 4'b0001) $display("FAIL basic_used: got %b want 0001", buffers_used_o); else pass_cnt++;
      chk_cnt++; if (fifo_count_o !== 5'd0) $display("FAIL basic_count_done: got %0d want 0", fifo_count_o); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      logic [3:0] exp_used;
      do_reset;
      busy = 1'b1;
      exp_used = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         trig = 1'b1; trig_id = 32'hA000_0000 + 32'(i);
         tick;
         exp_used = {exp_used[2:0], 1'b1};
         chk_cnt++; if (trig_ack_o !== 1'b1) $display("FAIL b2b_ack%0d: got %b want 1", i, trig_ack_o); else pass_cnt++;
         chk_cnt++; if (buffers_used_o !== exp_used) $display("FAIL b2b_used%0d: got %b want %b", i, buffers_used_o, exp_used); else pass_cnt++;
         chk_cnt++; if (fifo_count_o !== 5'(i + 1)) $display("FAIL b2b_count%0d: got %0d want %0d", i, fifo_count_o, i + 1); else pass_cnt++;
      end
      trig_id = 32'hA000_0004;
      tick;
      trig = 1'b0;
      chk_cnt++; if (trig_drop_o !== 1'b1 || trig_ack_o !== 1'b0) $display("FAIL b2b_drop: got drop=%b ack=%b want drop=1 ack=0", trig_drop_o, trig_ack_o); else pass_cnt++;
      chk_cnt++; if (drop_count_o !== 16'd1) $display("FAIL b2b_drop_count: got %0d want 1", drop_count_o); else pass_cnt++;
      chk_cnt++; if (fifo_count_o !== 5'd4) $display("FAIL b2b_count_full: got %0d want 4", fifo_count_o); else pass_cnt++;
      tick;
      chk_cnt++; if (start_o !== 1'b0 || trig_drop_o !== 1'b0) $display("FAIL b2b_quiet: got start=%b drop=%b want 0 0", start_o, trig_drop_o); else pass_cnt++;
   endtask

   task automatic test_release_same_cycle;
      do_reset;
      busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         trig = 1'b1; trig_id = 32'hB000_0000 + 32'(i);
         tick;
      end
      trig = 1'b0; busy = 1'b0;
      tick;
      chk_cnt++; if (start_o !== 1'b1 || buffer_o !== 2'd0) $display("FAIL rel_first_start: got start=%b buf=%0d want 1 0", start_o, buffer_o); else pass_cnt++;
      tick;
      done = 1'b1;
      tick;
      done = 1'b0;
      chk_cnt++; if (fifo_count_o !== 5'd3 || buffers_used_o !== 4'b1111) $display("FAIL rel_pre: got count=%0d used=%b want 3 1111", fifo_count_o, buffers_used_o); else pass_cnt++;
      rel = 4'b0010; trig = 1'b1; trig_id = 32'hB100_0000;
      tick;
      rel = 4'd0; trig_id = 32'hC000_0001;
      chk_cnt++; if (trig_drop_o !== 1'b1 || trig_ack_o !== 1'b0) $display("FAIL rel_same_cycle_drop: got drop=%b ack=%b want 1 0", trig_drop_o, trig_ack_o); else pass_cnt++;
      chk_cnt++; if (buffers_used_o !== 4'b1101) $display("FAIL rel_cleared: got %b want 1101", buffers_used_o); else pass_cnt++;
      tick;
      trig = 1'b0;
      chk_cnt++; if (trig_ack_o !== 1'b1) $display("FAIL rel_next_ack: got %b want 1", trig_ack_o); else pass_cnt++;
      chk_cnt++; if (buffers_used_o !== 4'b1111 || fifo_count_o !== 5'd4) $display("FAIL rel_buf1_alloc: got used=%b count=%0d want 1111 4", buffers_used_o, fifo_count_o); else pass_cnt++;
   endtask

   task automatic test_busy_hold;
      int bad;
      do_reset;
      busy = 1'b1;
      trig = 1'b1; trig_id = 32'hDEAD0001;
      tick;
      trig_id = 32'hDEAD0002;
      tick;
      trig = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (start_o !== 1'b0) bad++;
      end
      chk_cnt++; if (bad != 0 || fifo_count_o !== 5'd2) $display("FAIL busy_hold: got starts=%0d count=%0d want 0 2", bad, fifo_count_o); else pass_cnt++;
      busy = 1'b0;
      tick;
      chk_cnt++; if (start_o !== 1'b1 || event_id_o !== 32'hDEAD0001 || buffer_o !== 2'd0) $display("FAIL busy_start1: got start=%b id=%h buf=%0d want 1 dead0001 0", start_o, event_id_o, buffer_o); else pass_cnt++;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (start_o !== 1'b0 || event_id_o !== 32'hDEAD0001 || buffer_o !== 2'd0) bad++;
      end
      chk_cnt++; if (bad != 0) $display("FAIL busy_stable1: got %0d bad cycles want 0", bad); else pass_cnt++;
      done = 1'b1;
      tick;
      done = 1'b0;
      chk_cnt++; if (start_o !== 1'b0 || fifo_count_o !== 5'd1 || idle_o !== 1'b0) $display("FAIL busy_done1: got start=%b count=%0d idle=%b want 0 1 0", start_o, fifo_count_o, idle_o); else pass_cnt++;
      tick;
      chk_cnt++; if (start_o !== 1'b1 || event_id_o !== 32'hDEAD0002 || buffer_o !== 2'd1) $display("FAIL busy_start2: got start=%b id=%h buf=%0d want 1 dead0002 1", start_o, event_id_o, buffer_o); else pass_cnt++;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick;
         if (start_o !== 1'b0 || event_id_o !== 32'hDEAD0002) bad++;
      end
      chk_cnt++; if (bad != 0) $display("FAIL busy_stable2: got %0d bad cycles want 0", bad); else pass_cnt++;
      done = 1'b1;
      tick;
      done = 1'b0;
      chk_cnt++; if (fifo_count_o !== 5'd0 || idle_o !== 1'b1 || buffers_used_o !== 4'b0011) $display("FAIL busy_drain: got count=%0d idle=%b used=%b want 0 1 0011", fifo_count_o, idle_o, buffers_used_o); else pass_cnt++;
   endtask

   task automatic test_timeout;
      int seen;
      do_reset;
      trig = 1'b1; trig_id = 32'h0BADF00D;
      tick;
      trig = 1'b0;
      tick;
      chk_cnt++; if (start_o !== 1'b1) $display("FAIL to_start: got %b want 1", start_o); else pass_cnt++;
      seen = 0;
`ifdef SCHED_TIMEOUT_EN
      for (int i = 0; i < 64; i++) begin
         tick;
         if (timeout_o !== 1'b0) seen++;
      end
      chk_cnt++; if (seen != 0) $display("FAIL to_early: got %0d pulses want 0", seen); else pass_cnt++;
      tick;
      chk_cnt++; if (timeout_o !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout_o); else pass_cnt++;
      chk_cnt++; if (fifo_count_o !== 5'd0 || buffers_used_o !== 4'b0001) $display("FAIL to_pop: got count=%0d used=%b want 0 0001", fifo_count_o, buffers_used_o); else pass_cnt++;
      tick;
      chk_cnt++; if (timeout_o !== 1'b0) $display("FAIL to_pulse_end: got %b want 0", timeout_o); else pass_cnt++;
`else
      for (int i = 0; i < 1000; i++) begin
         tick;
         if (timeout_o !== 1'b0) seen++;
      end
      chk_cnt++; if (seen != 0) $display("FAIL no_timeout: got %0d pulses want 0", seen); else pass_cnt++;
      chk_cnt++; if (fifo_count_o !== 5'd1 || idle_o !== 1'b0) $display("FAIL no_timeout_wait: got count=%0d idle=%b want 1 0", fifo_count_o, idle_o); else pass_cnt++;
`endif
   endtask

   task automatic test_reset_midcmd;
      do_reset;
      busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         trig = 1'b1; trig_id = 32'hE000_0000 + 32'(i);
         tick;
      end
      trig = 1'b0; busy = 1'b0;
      tick; tick; tick;
      chk_cnt++; if (fifo_count_o !== 5'd3 || start_o !== 1'b0 || event_id_o !== 32'hE000_0000) $display("FAIL mid_pre: got count=%0d start=%b id=%h want 3 0 e0000000", fifo_count_o, start_o, event_id_o); else pass_cnt++;
      #2;
      rst = 1'b1;
      #1;
      chk_cnt++; if (all_o !== 64'd1) $display("FAIL mid_async_reset: got %h want %h", all_o, 64'd1); else pass_cnt++;
      tick;
      rst = 1'b0;
      trig = 1'b1; trig_id = 32'hF000_0001;
      tick;
      trig = 1'b0;
      chk_cnt++; if (trig_ack_o !== 1'b1 || buffers_used_o !== 4'b0001 || fifo_count_o !== 5'd1) $display("FAIL mid_after_alloc: got ack=%b used=%b count=%0d want 1 0001 1", trig_ack_o, buffers_used_o, fifo_count_o); else pass_cnt++;
      tick;
      chk_cnt++; if (start_o !== 1'b1 || buffer_o !== 2'd0 || event_id_o !== 32'hF000_0001) $display("FAIL mid_after_start: got start=%b buf=%0d id=%h want 1 0 f0000001", start_o, buffer_o, event_id_o); else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_release_same_cycle;
      test_busy_hold;
      test_timeout;
      test_reset_midcmd;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
